cb_addr_sched: RTL and testbench

Sequencer for the CB address-shift datapath. On a start pulse it walks `landmark_num` landmark groups. Each group lasts `STATE_CNT_MAX+1` cycles. Every cycle it produces the per-stage enable wavefront `en`, the bank-0 row address `din` and the shift-direction bit `dir`, which is the group parity. The block sits between the top-level step FSM and the address-shift register array, and owns the state/group counters that the shift block does not have.

---
 rtl/cb_addr_sched.sv | 139 +++++++++++++
 tb/tb_cb_addr_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_addr_sched.sv
// cb_addr_sched: sequencer for the CB address-shift datapath.
// Walks landmark_num groups of STATE_CNT_MAX+1 cycles each. Every cycle it
// produces the stage-enable wavefront (en), the bank-0 row address (din) and
// the shift direction (dir = group parity). After the last group it drains
// the enable wavefront for L cycles and then pulses done.
//
// Handshake: start is a single-cycle request that is only honoured in IDLE;
// a start seen in any other state (including the done cycle) is dropped.
// stall freezes every controller register while in RUN or DRAIN.
//
// The FSM state is exposed on fsm_state so checkers can observe the
// controller phase directly.
module cb_addr_sched #(
  parameter int L             = 4,
  parameter int DW            = 16,
  parameter int ROW_LEN       = 10,
  parameter int STATE_CNT_MAX = 5
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               stall,
  input  logic [ROW_LEN-1:0] landmark_num,
  input  logic [DW-1:0]      base_addr,
  input  logic [DW-1:0]      row_stride,
  output logic [L-1:0]       en,
  output logic [DW-1:0]      din,
  output logic               dir,
  output logic [2:0]         state_cnt,
  output logic [ROW_LEN-1:0] group_cnt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         fsm_state
);

  localparam int DCW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [ROW_LEN-1:0] lm_num;
  logic [DW-1:0]      stride;
  logic [DW-1:0]      row_base;
  logic [DCW-1:0]     drain_cnt;

  assign fsm_state = state;

  // Controller: state, counters, latched parameters and all registered outputs.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      lm_num    <= '0;
      stride    <= '0;
      row_base  <= '0;
      drain_cnt <= '0;
      en        <= '0;
      din       <= '0;
      dir       <= 1'b0;
      state_cnt <= '0;
      group_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            lm_num <= landmark_num;
            stride <= row_stride;
            if (landmark_num != '0) begin
              row_base  <= base_addr;
              din       <= base_addr;
              state_cnt <= '0;
              group_cnt <= '0;
              dir       <= 1'b0;
              en        <= {{(L-1){1'b0}}, 1'b1};
              drain_cnt <= '0;
              busy      <= 1'b1;
              state     <= S_RUN;
            end else begin
              // Nothing to walk: report completion immediately.
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_RUN: begin
          if (!stall) begin
            en <= {en[L-2:0], 1'b1};
            if (state_cnt < 3'(STATE_CNT_MAX)) begin
              state_cnt <= state_cnt + 3'd1;
              din       <= row_base + DW'(state_cnt + 3'd1);
            end else if (group_cnt == lm_num - ROW_LEN'(1)) begin
              // Last group finished: stop feeding ones and flush the wavefront.
              state_cnt <= '0;
              din       <= '0;
              en        <= {en[L-2:0], 1'b0};
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              state_cnt <= '0;
              row_base  <= row_base + stride;
              din       <= row_base + stride;
              group_cnt <= group_cnt + ROW_LEN'(1);
              dir       <= ~group_cnt[0];
            end
          end
        end

        S_DRAIN: begin
          if (!stall) begin
            en <= {en[L-2:0], 1'b0};
            if (drain_cnt == DCW'(L - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              drain_cnt <= drain_cnt + DCW'(1);
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_addr_sched.sv
// Testbench for cb_addr_sched: directed runs checked every cycle against a
// position-based model of the output sequence, plus literal expectations.
module tb_cb_addr_sched;

  localparam int L    = 4;
  localparam int DW   = 16;
  localparam int RL   = 10;
  localparam int MAXS = 5;
  localparam int GLEN = MAXS + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic          stall;
  logic [RL-1:0] landmark_num;
  logic [DW-1:0] base_addr;
  logic [DW-1:0] row_stride;
  logic [L-1:0]  en;
  logic [DW-1:0] din;
  logic          dir;
  logic [2:0]    state_cnt;
  logic [RL-1:0] group_cnt;
  logic          busy;
  logic          done;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  cb_addr_sched #(.L(L), .DW(DW), .ROW_LEN(RL), .STATE_CNT_MAX(MAXS)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .stall        (stall),
    .landmark_num (landmark_num),
    .base_addr    (base_addr),
    .row_stride   (row_stride),
    .en           (en),
    .din          (din),
    .dir          (dir),
    .state_cnt    (state_cnt),
    .group_cnt    (group_cnt),
    .busy         (busy),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = idle, 1 = active at output position m_pos (RUN positions first,
  // then L drain positions), 2 = completion cycle.
  int            m_phase;
  int            m_pos;
  logic [RL-1:0] m_lm;
  logic [DW-1:0] m_base;
  logic [DW-1:0] m_stride;

  always @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_phase <= 0;
      m_pos   <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_lm     <= landmark_num;
             m_base   <= base_addr;
             m_stride <= row_stride;
             m_pos    <= 0;
             m_phase  <= (landmark_num == '0) ? 2 : 1;
           end
        1: if (!stall) begin
             if (m_pos == int'(m_lm) * GLEN + L - 1) m_phase <= 2;
             else m_pos <= m_pos + 1;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin : cmp
    logic [L-1:0]  e_en;
    logic [DW-1:0] e_din;
    logic          e_busy, e_done;
    int            r, g, k, d;
    e_en = '0; e_din = '0; e_busy = 1'b0; e_done = 1'b0;
    r = int'(m_lm) * GLEN;
    g = 0; k = 0;
    if (m_phase == 1) begin
      e_busy = 1'b1;
      if (m_pos < r) begin
        g = m_pos / GLEN;
        k = m_pos % GLEN;
        e_din = m_base + DW'(g) * m_stride + DW'(k);
        e_en  = (m_pos + 1 >= L) ? {L{1'b1}} : L'((1 << (m_pos + 1)) - 1);
      end else begin
        d = m_pos - r;
        g = int'(m_lm) - 1;
        e_en = L'({L{1'b1}} << (d + 1));
      end
    end else if (m_phase == 2) begin
      e_done = 1'b1;
    end
    chk("en", 32'(en), 32'(e_en));
    chk("din", 32'(din), 32'(e_din));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (m_phase == 1) begin
      chk("group_cnt", 32'(group_cnt), 32'(g));
      chk("dir", 32'(dir), 32'(g % 2));
      if (m_pos < r) chk("state_cnt", 32'(state_cnt), 32'(k));
    end
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] h_din [0:63];
  logic [L-1:0]  h_en  [0:63];
  logic          h_dir [0:63];
  logic          h_busy[0:63];

  // Pulses start, then records outputs per cycle (cycle 1 = first after the
  // start edge) until done, applying an optional stall window and an optional
  // extra start pulse. Returns the done cycle (0 on timeout).
  task automatic run_op(input logic [RL-1:0] lm, input logic [DW-1:0] b,
                        input logic [DW-1:0] s, input int stall_at,
                        input int stall_len, input int ign_at,
                        output int done_cyc);
    landmark_num = lm;
    base_addr    = b;
    row_stride   = s;
    start        = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cyc = 0;
    for (int n = 1; n < 64; n++) begin
      h_din[n]  = din;
      h_en[n]   = en;
      h_dir[n]  = dir;
      h_busy[n] = busy;
      if (done) begin
        done_cyc = n;
        break;
      end
      stall = (n >= stall_at) && (n < stall_at + stall_len);
      if (n == ign_at) begin
        start        = 1'b1;
        landmark_num = 10'd7;
        base_addr    = 16'h5555;
        row_stride   = 16'h0100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    stall = 1'b0;
    if (done_cyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int dc;

  initial begin
    sys_rst      = 1'b1;
    start        = 1'b0;
    stall        = 1'b0;
    landmark_num = '0;
    base_addr    = '0;
    row_stride   = '0;
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_grp", 32'(group_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    @(negedge clk);

    // Basic two-group run.
    run_op(10'd2, 16'h0100, 16'h0010, 0, 0, 0, dc);
    chk("t1_done_cycle", 32'(dc), 32'd17);
    chk("t1_din1", 32'(h_din[1]), 32'h0100);
    chk("t1_din6", 32'(h_din[6]), 32'h0105);
    chk("t1_din7", 32'(h_din[7]), 32'h0110);
    chk("t1_din12", 32'(h_din[12]), 32'h0115);
    chk("t1_din13", 32'(h_din[13]), 32'h0000);
    chk("t1_en3", 32'(h_en[3]), 32'b0111);
    chk("t1_en12", 32'(h_en[12]), 32'b1111);
    chk("t1_en13", 32'(h_en[13]), 32'b1110);
    chk("t1_en14", 32'(h_en[14]), 32'b1100);
    chk("t1_en16", 32'(h_en[16]), 32'b0000);
    chk("t1_dir6", 32'(h_dir[6]), 32'd0);
    chk("t1_dir7", 32'(h_dir[7]), 32'd1);
    chk("t1_busy17", 32'(h_busy[17]), 32'd0);
    @(negedge clk);

    // Zero groups, then a start in the done cycle which must be dropped.
    run_op(10'd0, 16'h0100, 16'h0010, 0, 0, 0, dc);
    chk("t2_done_cycle", 32'(dc), 32'd1);
    chk("t2_en", 32'(h_en[1]), 32'd0);
    landmark_num = 10'd2;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_drop_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_drop_busy2", 32'(busy), 32'd0);

    // Stall for 3 cycles while state_cnt = 2 in group 0.
    run_op(10'd2, 16'h0100, 16'h0010, 3, 3, 0, dc);
    chk("t3_done_cycle", 32'(dc), 32'd20);
    chk("t3_din3", 32'(h_din[3]), 32'h0102);
    chk("t3_din6", 32'(h_din[6]), 32'h0102);
    chk("t3_din7", 32'(h_din[7]), 32'h0103);
    chk("t3_en6", 32'(h_en[6]), 32'b0111);
    @(negedge clk);

    // Address wrap with an ignored start during RUN.
    run_op(10'd1, 16'hFFFE, 16'h0001, 0, 0, 2, dc);
    chk("t4_done_cycle", 32'(dc), 32'd11);
    chk("t4_din2", 32'(h_din[2]), 32'hFFFF);
    chk("t4_din3", 32'(h_din[3]), 32'h0000);
    chk("t4_din6", 32'(h_din[6]), 32'h0003);
    @(negedge clk);

    // Asynchronous reset in cycle 8 of a two-group run.
    landmark_num = 10'd2;
    base_addr    = 16'h0100;
    row_stride   = 16'h0010;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("t5_pre_din", 32'(din), 32'h0111);
    #2 sys_rst = 1'b1;
    #1;
    chk("t5_rst_en", 32'(en), 32'd0);
    chk("t5_rst_din", 32'(din), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_grp", 32'(group_cnt), 32'd0);
    chk("t5_rst_dir", 32'(dir), 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(10'd2, 16'h0100, 16'h0010, 0, 0, 0, dc);
    chk("t5_done_cycle", 32'(dc), 32'd17);
    chk("t5_din1", 32'(h_din[1]), 32'h0100);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
